// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths, named register indices and the
// register-file clear sequencer state encoding.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks r1..r(N-1), zeroing one register per cycle,
// and holds busy for the whole walk. r0 is skipped since it is hardwired zero.
module regfile_clr_seq
    import mips_pkg::*;
#(
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output rf_state_t         state,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] cnt;

    // clr_req is taken on any edge seen in IDLE and ignored while CLEAR;
    // busy is a flop, so upstream sees it one edge after the request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/mips_regfile.sv
// 32-entry MIPS register file: two combinational read ports with optional
// same-cycle write forwarding, one synchronous write port, bulk clear.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy
);

    localparam int                NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NREGS];
    rf_state_t         seq_state;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_en;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .state    (seq_state),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Writes are dropped while clearing; upstream is expected to stall on busy.
    assign wr_en = we && (seq_state == IDLE) && (wr_addr != ZERO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_we) begin
            regs[clr_addr] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == ZERO) begin
            rs_data = '0;
        end else if (BYPASS && wr_en && (wr_addr == rs_addr)) begin
            rs_data = wr_data;
        end
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == ZERO) begin
            rt_data = '0;
        end else if (BYPASS && wr_en && (wr_addr == rt_addr)) begin
            rt_data = wr_data;
        end
    end

endmodule

// File: tb/tb_mips_regfile.sv
// Bench for mips_regfile: drives a BYPASS=1 and a BYPASS=0 instance from the
// same inputs and compares both against a queue-based register model.
module tb_mips_regfile;

    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs_addr, rt_addr, wr_addr;
    logic        we, clr_req;
    logic [31:0] wr_data;
    logic [31:0] rs_b, rt_b, rs_n, rt_n;
    logic        busy_b, busy_n;

    logic [31:0] mdl [NR];
    int          clr_q[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n;

    // ---------------- clock / reset ----------------
    always #50 clk = ~clk;

    mips_regfile #(.BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_b), .rt_data(rt_b), .we(we), .wr_addr(wr_addr),
        .wr_data(wr_data), .clr_req(clr_req), .busy(busy_b)
    );

    mips_regfile #(.BYPASS(1'b0)) dut_nob (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_n), .rt_data(rt_n), .we(we), .wr_addr(wr_addr),
        .wr_data(wr_data), .clr_req(clr_req), .busy(busy_n)
    );

    // ---------------- reference model ----------------
    // Clear in progress == list of registers still to be zeroed, one per edge.
    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && we && clr_q.size() == 0 && wr_addr != 5'd0 && wr_addr == a)
            return wr_data;
        return mdl[a];
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
            clr_q.delete();
        end else if (clr_q.size() != 0) begin
            mdl[clr_q.pop_front()] = 32'h0;
        end else begin
            if (we && wr_addr != 5'd0) mdl[wr_addr] = wr_data;
            if (clr_req) for (int i = 1; i < NR; i++) clr_q.push_back(i);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_ports();
        exp_q.push_back(exp_read(rs_addr, 1'b1));
        exp_q.push_back(exp_read(rt_addr, 1'b1));
        exp_q.push_back(exp_read(rs_addr, 1'b0));
        exp_q.push_back(exp_read(rt_addr, 1'b0));
        exp_q.push_back({31'h0, clr_q.size() != 0});
        check("rs_byp", rs_b, exp_q.pop_front());
        check("rt_byp", rt_b, exp_q.pop_front());
        check("rs_nob", rs_n, exp_q.pop_front());
        check("rt_nob", rt_n, exp_q.pop_front());
        check("busy_byp", {31'h0, busy_b}, exp_q[0]);
        check("busy_nob", {31'h0, busy_n}, exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        #1;
        check_ports();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        step();
        we = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        rs_addr = a; rt_addr = a;
        #1;
        check($sformatf("%s_rs_r%0d", tag, a), rs_b, exp);
        check($sformatf("%s_rt_r%0d", tag, a), rt_n, exp);
    endtask

    task automatic count_busy(input string tag);
        n = 0;
        while (busy_b && n < 40) begin
            n++;
            step();
        end
        check(tag, n, 31);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; we = 1'b0; clr_req = 1'b0;
        rs_addr = '0; rt_addr = '0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < NR; i++) mdl[i] = 32'h0;
        repeat (2) begin
            model_edge();
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;

        // Reset clears stored data
        write_reg(5'd5, 32'hDEADBEEF);
        read_chk("pre_rst", 5'd5, 32'hDEADBEEF);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        read_chk("rst", 5'd5, 32'h0);
        check("rst_busy", {31'h0, busy_b}, 32'h0);

        // Basic write/read and r0
        write_reg(5'd7, 32'h12345678);
        read_chk("wr7", 5'd7, 32'h12345678);
        write_reg(5'd0, 32'hFFFFFFFF);
        read_chk("wr0", 5'd0, 32'h0);

        // Same-cycle forwarding
        write_reg(5'd9, 32'h11111111);
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
        rs_addr = 5'd9; rt_addr = 5'd9;
        #1;
        check("byp_rs", rs_b, 32'hA5A5A5A5);
        check("byp_rt", rt_b, 32'hA5A5A5A5);
        check("nob_rs", rs_n, 32'h11111111);
        check("nob_rt", rt_n, 32'h11111111);
        step();
        we = 1'b0;
        read_chk("byp_commit", 5'd9, 32'hA5A5A5A5);

        // Bulk clear with a blocked write mid-way
        for (int i = 1; i < NR; i++) write_reg(5'(i), 32'((i << 8) | i));
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("busy_rise", {31'h0, busy_b}, 32'h1);
        n = 0;
        while (busy_b && n < 40) begin
            n++;
            if (n == 11) begin
                for (int a = 1; a <= 10; a++) read_chk("mid_clr", 5'(a), 32'h0);
                read_chk("mid_clr", 5'd11, 32'h00000B0B);
                we = 1'b1; wr_addr = 5'd31; wr_data = 32'hCAFEF00D;
                read_chk("no_byp_busy", 5'd31, 32'h00001F1F);
                check("no_byp_busy_rt", rt_b, 32'h00001F1F);
            end
            step();
            we = 1'b0;
        end
        check("busy_len", n, 31);
        for (int a = 0; a < NR; a++) read_chk("post_clr", 5'(a), 32'h0);

        // Reset in the 10th busy cycle, then a fresh full clear
        for (int i = 1; i < NR; i++) write_reg(5'(i), $urandom);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (9) step();
        check("busy_c10", {31'h0, busy_b}, 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_mid_busy", {31'h0, busy_b}, 32'h0);
        for (int a = 0; a < NR; a++) read_chk("rst_mid", 5'(a), 32'h0);
        write_reg(5'd20, 32'h20202020);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        count_busy("busy_len_restart");
        read_chk("restart_clr", 5'd20, 32'h0);

        // clr_req together with a write in IDLE
        clr_req = 1'b1; we = 1'b1; wr_addr = 5'd3; wr_data = 32'h3;
        step();
        clr_req = 1'b0; we = 1'b0;
        read_chk("sim_c1", 5'd3, 32'h3);
        step();
        read_chk("sim_c2", 5'd3, 32'h3);
        step();
        step();
        read_chk("sim_c4", 5'd3, 32'h0);
        n = 0;
        while (busy_b && n < 40) begin
            n++;
            step();
        end
        check("sim_idle", {31'h0, busy_b}, 32'h0);

        // Randomized traffic against the model
        repeat (800) begin
            rst_n   = ($urandom_range(0, 79) != 0);
            clr_req = ($urandom_range(0, 59) == 0);
            we      = $urandom_range(0, 1);
            wr_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            wr_data = $urandom;
            rs_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rt_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            step();
        end
        rst_n = 1'b1; clr_req = 1'b0; we = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
